alu_seq: RTL and testbench

Parametrised, sequential successor to the 8-bit ALU datapath. It holds two operand registers with persist/load/clear control and executes one of seven one-hot selected operations under a start/done handshake, including a multi-cycle shift-add multiply. It also registers carry/zero/overflow flags with the result and exposes its 2-bit current/next state for the top-level bench display. It sits between the operand input muxes and the output register stage of the ALU top level.

---
 rtl/alu_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: operand registers, one-hot op select, start/done handshake,
// single-cycle logic/arithmetic ops and a WIDTH-cycle shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [6:0]       out_sel,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       curr_state,
  output logic [1:0]       next_state
);

  localparam logic [1:0] S_OFF  = 2'b00;
  localparam logic [1:0] S_IDLE = 2'b01;
  localparam logic [1:0] S_BUSY = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  localparam logic [2:0] SEL_HOLD = 3'b100;
  localparam logic [2:0] SEL_LOAD = 3'b010;
  localparam logic [2:0] SEL_CLR  = 3'b001;

  // Wide enough that no shift amount representable in SHW bits loses bits.
  localparam int EXT = WIDTH + (1 << SHW);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [WIDTH-1:0]   r_a, r_b, r_out;
  logic               r_carry, r_zero, r_ovf, r_err;
  logic [1:0]         r_state, w_next;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_acc, r_mcand, w_acc_nxt;
  logic [WIDTH-1:0]   r_mplier;
  logic               w_start_ok, w_onehot, w_go, w_bad, w_mul_last;
  logic [WIDTH+1:0]   w_res;

  // Returns {ovf, carry, result} for every single-cycle operation.
  function automatic logic [WIDTH+1:0] alu_op(input logic [6:0] sel,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   ext;
    logic [EXT-1:0]   sh;
    logic [WIDTH-1:0] res;
    logic             c, o;
    ext = '0;
    sh  = '0;
    res = '0;
    c   = 1'b0;
    o   = 1'b0;
    if (sel[6]) begin
      ext = {1'b0, a} + {1'b0, b};
      res = ext[WIDTH-1:0];
      c   = ext[WIDTH];
      o   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
    end else if (sel[5]) begin
      ext = {1'b0, a} - {1'b0, b};
      res = ext[WIDTH-1:0];
      c   = ext[WIDTH];
      o   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
    end else if (sel[4]) begin
      res = a & b;
    end else if (sel[3]) begin
      res = a | b;
    end else if (sel[2]) begin
      res = a ^ b;
    end else if (sel[1]) begin
      sh  = EXT'(a) << b[SHW-1:0];
      res = sh[WIDTH-1:0];
      o   = |sh[EXT-1:WIDTH];
    end
    return {o, c, res};
  endfunction

  assign w_start_ok = on && (r_state == S_IDLE) && start && (in_sel == SEL_HOLD);
  assign w_onehot   = (out_sel != 7'd0) && ((out_sel & (out_sel - 7'd1)) == 7'd0);
  assign w_go       = w_start_ok && w_onehot;
  assign w_bad      = w_start_ok && !w_onehot;
  assign w_res      = alu_op(out_sel, r_a, r_b);
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_state == S_BUSY) && (r_cnt == CNT_LAST);

  always_comb begin
    w_next = r_state;
    if (!on) begin
      w_next = S_OFF;
    end else begin
      case (r_state)
        S_OFF:   w_next = S_IDLE;
        S_IDLE:  if (w_go) w_next = out_sel[0] ? S_BUSY : S_DONE;
        S_BUSY:  if (r_cnt == CNT_LAST) w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_OFF;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_bad;
      r_cnt   <= (r_state == S_BUSY) ? r_cnt + 1'b1 : '0;
      if (!on) begin
        r_out   <= '0;
        r_carry <= 1'b0;
        r_zero  <= 1'b0;
        r_ovf   <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (in_sel == SEL_LOAD) begin
          r_a <= num1;
          r_b <= num2;
        end else if (in_sel == SEL_CLR) begin
          r_a     <= '0;
          r_b     <= '0;
          r_out   <= '0;
          r_carry <= 1'b0;
          r_zero  <= 1'b0;
          r_ovf   <= 1'b0;
        end else if (w_go && !out_sel[0]) begin
          r_out   <= w_res[WIDTH-1:0];
          r_carry <= w_res[WIDTH];
          r_ovf   <= w_res[WIDTH+1];
          r_zero  <= (w_res[WIDTH-1:0] == '0);
        end
      end else if (w_mul_last) begin
        r_out   <= w_acc_nxt[WIDTH-1:0];
        r_carry <= 1'b0;
        r_ovf   <= |w_acc_nxt[2*WIDTH-1:WIDTH];
        r_zero  <= (w_acc_nxt[WIDTH-1:0] == '0);
      end
    end
  end

  // Multiplier datapath: seeded on start, one partial product per BUSY cycle.
  always_ff @(posedge clk) begin
    if (w_go) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, r_a};
      r_mplier <= r_b;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign out        = r_out;
  assign carry      = r_carry;
  assign zero       = r_zero;
  assign ovf        = r_ovf;
  assign busy       = (r_state == S_BUSY);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign curr_state = r_state;
  assign next_state = w_next;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed vectors, expected results
// queued at start and checked by a monitor whenever done is presented.
module tb_alu_seq;

  localparam logic [6:0] OP_ADD = 7'b1000000;
  localparam logic [6:0] OP_SUB = 7'b0100000;
  localparam logic [6:0] OP_AND = 7'b0010000;
  localparam logic [6:0] OP_OR  = 7'b0001000;
  localparam logic [6:0] OP_XOR = 7'b0000100;
  localparam logic [6:0] OP_SHL = 7'b0000010;
  localparam logic [6:0] OP_MUL = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst, on, start;
  logic [2:0] in_sel;
  logic [7:0] num1, num2, out;
  logic [6:0] out_sel;
  logic       carry, zero, ovf, busy, done, err;
  logic [1:0] curr_state, next_state;

  int n_chk  = 0;
  int n_fail = 0;
  logic [10:0] exp_q[$];

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .num1(num1), .num2(num2),
    .out_sel(out_sel), .start(start), .out(out), .carry(carry), .zero(zero),
    .ovf(ovf), .busy(busy), .done(done), .err(err), .curr_state(curr_state),
    .next_state(next_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got out=0x%0h, expected no done", out);
      end else begin
        check("done_result{out,c,z,o}", {out, carry, zero, ovf}, exp_q.pop_front());
      end
    end
    if (done && err) begin
      n_chk++;
      n_fail++;
      $display("FAIL err_with_done: got err=1 done=1, expected never both");
    end
  end

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    in_sel = 3'b010;
    num1   = a;
    num2   = b;
    tick();
    in_sel = 3'b100;
  endtask

  task automatic run_op(input string name, input logic [6:0] sel, input logic [7:0] eo,
                        input logic ec, input logic ez, input logic eov, input int lat);
    int n, nb;
    exp_q.push_back({eo, ec, ez, eov});
    out_sel = sel;
    start   = 1'b1;
    tick();
    start = 1'b0;
    n  = 1;
    nb = 0;
    while (!done && n < 30) begin
      if (busy) nb++;
      tick();
      n++;
    end
    check({name, "_latency"}, n, lat);
    if (lat > 1) check({name, "_busy_cycles"}, nb, lat - 1);
    tick();
    check({name, "_back_to_idle"}, curr_state, 2'b01);
  endtask

  initial begin
    rst = 1'b0; on = 1'b0; start = 1'b0; in_sel = 3'b100;
    num1 = 8'h00; num2 = 8'h00; out_sel = OP_ADD;
    #2;
    check("reset_state", curr_state, 2'b00);
    check("reset_out_flags", {out, carry, zero, ovf}, 11'h000);
    check("reset_busy_done_err", {busy, done, err}, 3'b000);
    check("reset_next_off", next_state, 2'b00);
    on = 1'b1;
    #1;
    check("reset_next_on", next_state, 2'b01);
    #10 rst = 1'b1;
    tick();
    check("off_to_idle", curr_state, 2'b01);

    load(8'h57, 8'h1A);
    run_op("add", OP_ADD, 8'h71, 1'b0, 1'b0, 1'b0, 1);
    run_op("sub", OP_SUB, 8'h3D, 1'b0, 1'b0, 1'b0, 1);
    run_op("and", OP_AND, 8'h12, 1'b0, 1'b0, 1'b0, 1);
    run_op("or",  OP_OR,  8'h5F, 1'b0, 1'b0, 1'b0, 1);
    run_op("xor", OP_XOR, 8'h4D, 1'b0, 1'b0, 1'b0, 1);
    run_op("shl", OP_SHL, 8'h5C, 1'b0, 1'b0, 1'b1, 1);

    out_sel = 7'b1100000;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("bad_sel_err", err, 1'b1);
    check("bad_sel_state", curr_state, 2'b01);
    check("bad_sel_out_held", {out, carry, zero, ovf}, {8'h5C, 3'b001});
    tick();
    check("bad_sel_err_pulse", err, 1'b0);

    load(8'h1A, 8'h57);
    run_op("sub_borrow", OP_SUB, 8'hC3, 1'b1, 1'b0, 1'b0, 1);
    load(8'h7F, 8'h01);
    run_op("add_ovf", OP_ADD, 8'h80, 1'b0, 1'b0, 1'b1, 1);
    load(8'hFF, 8'h01);
    run_op("add_carry_zero", OP_ADD, 8'h00, 1'b1, 1'b1, 1'b0, 1);

    in_sel = 3'b001;
    tick();
    in_sel = 3'b100;
    check("clear_out_flags", {out, carry, zero, ovf}, 11'h000);

    load(8'h57, 8'h1A);
    run_op("mul", OP_MUL, 8'hD6, 1'b0, 1'b0, 1'b1, 9);

    // Reset in the fourth BUSY cycle aborts with no done.
    out_sel = OP_MUL;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("pre_abort_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort_state", curr_state, 2'b00);
    check("abort_out", out, 8'h00);
    check("abort_done", done, 1'b0);
    tick();
    #2 rst = 1'b1;
    tick();
    check("abort_recover_idle", curr_state, 2'b01);

    in_sel  = 3'b010;
    num1    = 8'h33;
    num2    = 8'h44;
    out_sel = OP_ADD;
    start   = 1'b1;
    tick();
    start  = 1'b0;
    in_sel = 3'b100;
    check("load_wins_state", curr_state, 2'b01);
    check("load_wins_no_done", done, 1'b0);
    run_op("add_loaded", OP_ADD, 8'h77, 1'b0, 1'b0, 1'b0, 1);

    out_sel = OP_MUL;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    on = 1'b0;
    tick();
    check("on_low_state", curr_state, 2'b00);
    check("on_low_out", out, 8'h00);
    on = 1'b1;
    tick();
    check("on_high_idle", curr_state, 2'b01);

    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
